onchip_ram_arbiter: RTL and testbench

Two-master round-robin arbiter sharing the single-port 32768×32 on-chip RAM (registered address, unregistered output, byte enables, write gated by chipselect & write & debugaccess) between two Avalon-MM style requesters, e.g. the Nios instruction/data masters or a DMA. It issues one RAM access per cycle, returns read data with a one-cycle pipelined readdatavalid tagged to the issuing master, and enforces fairness under contention.

---
 rtl/onchip_ram_arbiter_pkg.sv | 7 +
 rtl/onchip_ram_arbiter_rr_arb2.sv | 19 +
 rtl/onchip_ram_arbiter.sv | 70 +++++++
 tb/tb_onchip_ram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_arbiter_pkg.sv
// onchip_ram_arbiter_pkg: default widths and master-id type shared by the arbiter files
package onchip_ram_arbiter_pkg;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_id_t;
endpackage

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; ports clk, reset, req[1:0] in, grant[1:0] out (one-hot or zero)
module rr_arb2
  import onchip_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  master_id_t last_grant_q, last_grant_d;
  always_comb begin
    grant = (&req) ? ((last_grant_q == M1) ? 2'b01 : 2'b10) : req;
    last_grant_d = grant[1] ? M1 : grant[0] ? M0 : last_grant_q;
  end
  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= M1;
    else       last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/onchip_ram_arbiter.sv
// onchip_ram_arbiter: shares one single-port RAM between two Avalon-MM masters; ports m0_*/m1_* slaves, ram_* RAM side
module onchip_ram_arbiter
  import onchip_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_debugaccess,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);
  logic [1:0] req, grant;
  logic       rd_pend_q, rd_pend_d;
  master_id_t rd_owner_q, rd_owner_d;
  // requests seen during reset are never granted
  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{~reset}};
  rr_arb2 u_arb (.clk(clk), .reset(reset), .req(req), .grant(grant));
  always_comb begin
    m0_waitrequest   = reset | ((m0_read | m0_write) & ~grant[0]);
    m1_waitrequest   = reset | ((m1_read | m1_write) & ~grant[1]);
    ram_address      = grant[1] ? m1_address : m0_address;
    ram_byteenable   = grant[1] ? m1_byteenable : m0_byteenable;
    ram_writedata    = grant[1] ? m1_writedata : m0_writedata;
    ram_chipselect   = |grant;
    // write takes priority when a master raises read and write together
    ram_write        = grant[1] ? m1_write : (grant[0] & m0_write);
    ram_debugaccess  = ram_write;
    ram_clken        = 1'b1;
    rd_pend_d        = ram_chipselect & ~ram_write;
    rd_owner_d       = grant[1] ? M1 : M0;
    // a read in flight when reset rises is dropped, not returned
    m0_readdatavalid = rd_pend_q & ~reset & (rd_owner_q == M0);
    m1_readdatavalid = rd_pend_q & ~reset & (rd_owner_q == M1);
    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= M0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb_onchip_ram_arbiter: scenario tasks against a behavioural arbiter/memory model with a RAM stand-in
module tb_onchip_ram_arbiter;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] m0_address, m1_address, ram_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, ram_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, ram_writedata, ram_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic ram_chipselect, ram_write, ram_debugaccess, ram_clken;
  always #5 clk = ~clk;
  onchip_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_debugaccess(ram_debugaccess), .ram_writedata(ram_writedata),
    .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );
  // RAM stand-in: registered address, unregistered output, gated byte-lane writes
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_q;
  always @(posedge clk) begin
    if (ram_clken) begin
      ram_addr_q <= ram_address;
      if (ram_chipselect & ram_write & ram_debugaccess)
        for (int b = 0; b < BW; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
    end
  end
  assign ram_readdata = mem[ram_addr_q];
  // reference model state
  logic [DW-1:0] ref_mem [int];
  int last = 1;
  int win;
  bit pend_v;
  int pend_o;
  logic [DW-1:0] pend_d;
  bit ew0, ew1, ev0, ev1, ecs;
  int checks = 0;
  int errors = 0;
  string nm;
  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 'x;
  endfunction
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction
  task automatic drive0(input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    m0_read = r; m0_write = w; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask
  task automatic drive1(input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    m1_read = r; m1_write = w; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask
  task automatic idle();
    drive0(0, 0, '0, '0, '0);
    drive1(0, 0, '0, '0, '0);
  endtask
  // mid-cycle: derive what the rules say this cycle must look like
  task automatic settle();
    bit q0, q1;
    #4;
    q0 = m0_read | m0_write;
    q1 = m1_read | m1_write;
    win = reset ? -1 : (q0 && q1) ? 1 - last : q0 ? 0 : q1 ? 1 : -1;
    ew0 = reset || (q0 && win != 0);
    ew1 = reset || (q1 && win != 1);
    ev0 = !reset && pend_v && pend_o == 0;
    ev1 = !reset && pend_v && pend_o == 1;
    ecs = win >= 0;
  endtask
  // commit this cycle's effects to the model, then move past the next edge
  task automatic advance();
    int a;
    pend_v = 0;
    if (reset) last = 1;
    else if (win >= 0) begin
      last = win;
      a = int'(win == 1 ? m1_address : m0_address);
      if (win == 1 ? m1_write : m0_write)
        ref_mem[a] = merge(ref_rd(a), win == 1 ? m1_writedata : m0_writedata, win == 1 ? m1_byteenable : m0_byteenable);
      else begin
        pend_v = 1; pend_o = win; pend_d = ref_rd(a);
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    nm = "reset";
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      drive0(1, 0, 15'h1, 4'hF, '0);
      drive1(0, 1, 15'h2, 4'hF, 32'h1);
      settle();
      checks += 5;
      if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL %s m0_waitrequest got %b exp 1", nm, m0_waitrequest); end
      if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp 1", nm, m1_waitrequest); end
      if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp 0", nm, m0_readdatavalid); end
      if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp 0", nm, m1_readdatavalid); end
      if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL %s ram_chipselect got %b exp 0", nm, ram_chipselect); end
      advance();
    end
    reset = 0;
    idle();
  endtask
  task automatic test_fill();
    nm = "fill";
    for (int i = 0; i < 17; i++) begin
      idle();
      if (i < 16 && i % 2 == 0) drive0(0, 1, AW'(i), 4'hF, $urandom);
      if (i < 16 && i % 2 == 1) drive1(0, 1, AW'(i), 4'hF, $urandom);
      settle();
      checks += 6;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if ((ram_write & ram_debugaccess) !== (i < 16)) begin errors++; $display("FAIL %s ram_write got %b exp %b", nm, ram_write, i < 16); end
      advance();
    end
  endtask
  task automatic test_write_read();
    nm = "write_read";
    for (int c = 0; c < 3; c++) begin
      idle();
      if (c == 0) drive0(0, 1, 15'h0010, 4'hF, 32'hDEADBEEF);
      if (c == 1) drive0(1, 0, 15'h0010, 4'h0, '0);
      settle();
      checks += 5;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if (c == 2) begin
        checks++;
        if (m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL %s readdata got %h exp deadbeef", nm, m0_readdata); end
      end
      advance();
    end
  endtask
  task automatic test_byteenable();
    nm = "byteenable";
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) drive1(0, 1, 15'h0020, 4'hF, 32'hAABBCCDD);
      if (c == 1) drive1(0, 1, 15'h0020, 4'b0101, 32'h11223344);
      if (c == 2) drive1(1, 0, 15'h0020, 4'h0, '0);
      settle();
      checks += 5;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if (c == 3) begin
        checks++;
        if (m1_readdata !== 32'hAA22CC44) begin errors++; $display("FAIL %s readdata got %h exp aa22cc44", nm, m1_readdata); end
      end
      advance();
    end
  endtask
  task automatic test_contention();
    int a0, a1, n0, n1;
    nm = "contention";
    a0 = 0; a1 = 8; n0 = 0; n1 = 0;
    reset = 1; idle(); settle(); advance(); reset = 0;
    for (int c = 0; c < 11; c++) begin
      idle();
      if (c < 10) begin
        drive0(1, 0, AW'(a0), 4'h0, '0);
        drive1(1, 0, AW'(a1), 4'h0, '0);
      end
      settle();
      checks += 6;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if (c < 10 && m0_waitrequest !== (c % 2 == 1)) begin errors++; $display("FAIL %s alternation cycle %0d m0_waitrequest got %b exp %b", nm, c, m0_waitrequest, c % 2 == 1); end
      if (ev0 || ev1) begin
        checks++;
        if (m0_readdata !== pend_d || m1_readdata !== pend_d) begin errors++; $display("FAIL %s readdata got %h/%h exp %h", nm, m0_readdata, m1_readdata, pend_d); end
      end
      n0 += int'(m0_readdatavalid === 1'b1);
      n1 += int'(m1_readdatavalid === 1'b1);
      if (win == 0) a0++;
      if (win == 1) a1++;
      advance();
    end
    checks += 2;
    if (n0 != 5) begin errors++; $display("FAIL %s m0 valid count got %0d exp 5", nm, n0); end
    if (n1 != 5) begin errors++; $display("FAIL %s m1 valid count got %0d exp 5", nm, n1); end
  endtask
  task automatic test_write_wins();
    bit m1_done;
    nm = "write_wins";
    m1_done = 0;
    for (int c = 0; c < 3; c++) begin
      idle();
      if (c == 0) drive0(0, 1, 15'h0100, 4'hF, 32'h5);
      if (!m1_done) drive1(1, 0, 15'h0100, 4'h0, '0);
      settle();
      checks += 5;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if (c == 2) begin
        checks++;
        if (m1_readdata !== 32'h5) begin errors++; $display("FAIL %s readdata got %h exp 00000005", nm, m1_readdata); end
      end
      if (win == 1) m1_done = 1;
      advance();
    end
  endtask
  task automatic test_reset_inflight();
    nm = "reset_inflight";
    for (int c = 0; c < 4; c++) begin
      idle();
      reset = (c == 1);
      if (c == 0) drive0(1, 0, 15'h0003, 4'h0, '0);
      if (c == 1 || c == 2) begin
        drive0(1, 0, 15'h0004, 4'h0, '0);
        drive1(1, 0, 15'h0005, 4'h0, '0);
      end
      settle();
      checks += 5;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if (c == 2) begin
        checks++;
        if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL %s first grant got wait %b/%b exp 0/1", nm, m0_waitrequest, m1_waitrequest); end
      end
      advance();
    end
    reset = 0;
  endtask
  task automatic test_single();
    nm = "single";
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c < 4) begin
        if ($urandom_range(0, 1) == 1) drive1(1, 0, AW'($urandom_range(0, 15)), 4'h0, '0);
        else drive1(0, 1, AW'($urandom_range(0, 15)), BW'($urandom), $urandom);
      end
      settle();
      checks += 5;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if (ev0 || ev1) begin
        checks++;
        if (m1_readdata !== pend_d) begin errors++; $display("FAIL %s readdata got %h exp %h", nm, m1_readdata, pend_d); end
      end
      advance();
    end
  endtask
  task automatic test_random();
    bit act0, act1, w;
    nm = "random";
    act0 = 0; act1 = 0;
    idle();
    for (int c = 0; c < 300; c++) begin
      // a master keeps its request unchanged until the model says it was granted
      if (!act0) begin
        w = ($urandom_range(0, 1) == 1);
        if (c < 298 && $urandom_range(0, 9) < 6) begin act0 = 1; drive0(!w, w, AW'($urandom_range(0, 15)), BW'($urandom), $urandom); end
        else drive0(0, 0, '0, '0, '0);
      end
      if (!act1) begin
        w = ($urandom_range(0, 1) == 1);
        if (c < 298 && $urandom_range(0, 9) < 6) begin act1 = 1; drive1(!w, w, AW'($urandom_range(0, 15)), BW'($urandom), $urandom); end
        else drive1(0, 0, '0, '0, '0);
      end
      settle();
      checks += 5;
      if (m0_waitrequest !== ew0) begin errors++; $display("FAIL %s m0_waitrequest got %b exp %b", nm, m0_waitrequest, ew0); end
      if (m1_waitrequest !== ew1) begin errors++; $display("FAIL %s m1_waitrequest got %b exp %b", nm, m1_waitrequest, ew1); end
      if (m0_readdatavalid !== ev0) begin errors++; $display("FAIL %s m0_readdatavalid got %b exp %b", nm, m0_readdatavalid, ev0); end
      if (m1_readdatavalid !== ev1) begin errors++; $display("FAIL %s m1_readdatavalid got %b exp %b", nm, m1_readdatavalid, ev1); end
      if (ram_chipselect !== ecs) begin errors++; $display("FAIL %s ram_chipselect got %b exp %b", nm, ram_chipselect, ecs); end
      if (ev0 || ev1) begin
        checks++;
        if (m0_readdata !== pend_d || m1_readdata !== pend_d) begin errors++; $display("FAIL %s readdata got %h/%h exp %h", nm, m0_readdata, m1_readdata, pend_d); end
      end
      if (win == 0) act0 = 0;
      if (win == 1) act1 = 0;
      advance();
    end
  endtask
  initial begin
    idle();
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_write_read();
    test_byteenable();
    test_contention();
    test_write_wins();
    test_reset_inflight();
    test_single();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
